// File: rtl/arith_mon_pkg.sv
// Shared types and constants for the arithmetic sweep monitor.
// Optional feature macro: ARITH_MON_GOLDEN_EN (adds golden a*(b+c) check, widens err_mask).
package arith_mon_pkg;

    localparam int unsigned NUM_SEL = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned OPND_W  = 8;

`ifdef ARITH_MON_GOLDEN_EN
    localparam int unsigned ERR_W   = 3;
`else
    localparam int unsigned ERR_W   = 2;
`endif

    // Select codes whose results must agree pairwise
    localparam logic [SEL_W-1:0] SEL_T1   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_T2   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_T3   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_T4   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_CHECK,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/arith_mon_if.sv
// Operand, datapath, result and error signals of the sweep monitor.
// err_mask width follows ARITH_MON_GOLDEN_EN through ERR_W.
interface arith_mon_if;
    import arith_mon_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPND_W-1:0]    in_a, in_b, in_c, in_d, in_e;
    logic [OPND_W-1:0]    du_a, du_b, du_c, du_d, du_e;
    logic [SEL_W-1:0]     du_sel;
    logic [WORD_W-1:0]    du_y;
    logic                 res_valid;
    logic                 res_ready;
    logic [WORD_W-1:0]    res_word;
    logic [SEL_W-1:0]     res_sel;
    logic                 res_last;
    logic                 err_pulse;
    logic [ERR_W-1:0]     err_mask;
    logic [CNT_W-1:0]     err_count;

    // Monitor side
    modport master (
        input  in_valid, in_a, in_b, in_c, in_d, in_e, du_y, res_ready,
        output in_ready, du_a, du_b, du_c, du_d, du_e, du_sel,
               res_valid, res_word, res_sel, res_last,
               err_pulse, err_mask, err_count
    );

    // Environment side: operand source, datapath and result sink
    modport slave (
        output in_valid, in_a, in_b, in_c, in_d, in_e, du_y, res_ready,
        input  in_ready, du_a, du_b, du_c, du_d, du_e, du_sel,
               res_valid, res_word, res_sel, res_last,
               err_pulse, err_mask, err_count
    );

endinterface

// File: rtl/arith_mon_buf.sv
// 8x16 capture buffer: write by select code, combinational read by index,
// plus fixed taps on the four identity words.
module arith_mon_buf
    import arith_mon_pkg::*;
(
    input  logic                           clk,
    input  logic                           i_wr_en,
    input  logic [SEL_W-1:0]               i_wr_sel,
    input  logic [WORD_W-1:0]              i_wr_data,
    input  logic [SEL_W-1:0]               i_rd_idx,
    output logic [WORD_W-1:0]              o_rd_data,
    output logic [3:0][WORD_W-1:0]         o_taps
);

    logic [WORD_W-1:0] r_mem [NUM_SEL];

    // Capture storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_sel] <= i_wr_data;
        end
    end

    // Read ports
    always_comb begin
        o_rd_data = r_mem[i_rd_idx];
        o_taps[0] = r_mem[SEL_T1];
        o_taps[1] = r_mem[SEL_T2];
        o_taps[2] = r_mem[SEL_T3];
        o_taps[3] = r_mem[SEL_T4];
    end

endmodule

// File: rtl/arith_sweep_monitor.sv
// Sweeps the datapath select over all codes for each operand set, checks the
// algebraic identities, then streams captured words out.
// Optional feature macro: ARITH_MON_GOLDEN_EN (golden a*(b+c) compare on word 0).
module arith_sweep_monitor
    import arith_mon_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    arith_mon_if.master bus
);

    state_t                r_state, w_nxt_state;
    logic                  r_in_ready, w_nxt_in_ready;
    logic [OPND_W-1:0]     r_du_a, r_du_b, r_du_c, r_du_d, r_du_e;
    logic [OPND_W-1:0]     w_nxt_du_a, w_nxt_du_b, w_nxt_du_c, w_nxt_du_d, w_nxt_du_e;
    logic [SEL_W-1:0]      r_du_sel, w_nxt_du_sel;
    logic                  r_res_valid, w_nxt_res_valid;
    logic [WORD_W-1:0]     r_res_word, w_nxt_res_word;
    logic [SEL_W-1:0]      r_res_sel, w_nxt_res_sel;
    logic                  r_res_last, w_nxt_res_last;
    logic                  r_err_pulse, w_nxt_err_pulse;
    logic [ERR_W-1:0]      r_err_mask, w_nxt_err_mask;
    logic [CNT_W-1:0]      r_err_count, w_nxt_err_count;

    logic                  w_wr_en;
    logic [SEL_W-1:0]      w_rd_idx;
    logic [WORD_W-1:0]     w_rd_data;
    logic [3:0][WORD_W-1:0] w_taps;
    logic [ERR_W-1:0]      w_mask;

    arith_mon_buf u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_sel  (r_du_sel),
        .i_wr_data (bus.du_y),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .o_taps    (w_taps)
    );

    // Buffer read index: word 0 when entering emit, otherwise the next word
    always_comb begin
        w_rd_idx = r_res_sel + 3'd1;
        if (r_state == ST_CHECK) begin
            w_rd_idx = SEL_T1;
        end
    end

`ifdef ARITH_MON_GOLDEN_EN
    logic [WORD_W-1:0] w_golden;

    // Golden a*(b+c) from the latched operands, modulo 2^16
    always_comb begin
        w_golden = WORD_W'(r_du_a) * (WORD_W'(r_du_b) + WORD_W'(r_du_c));
    end
`endif

    // Identity comparators; taps 0..3 are complete once sel 7 is being captured
    always_comb begin
        w_mask    = '0;
        w_mask[0] = (w_taps[0] != w_taps[1]);
        w_mask[1] = (w_taps[2] != w_taps[3]);
`ifdef ARITH_MON_GOLDEN_EN
        w_mask[2] = (w_taps[0] != w_golden);
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_du_a      <= '0;
            r_du_b      <= '0;
            r_du_c      <= '0;
            r_du_d      <= '0;
            r_du_e      <= '0;
            r_du_sel    <= '0;
            r_res_valid <= 1'b0;
            r_res_word  <= '0;
            r_res_sel   <= '0;
            r_res_last  <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_mask  <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_in_ready  <= w_nxt_in_ready;
            r_du_a      <= w_nxt_du_a;
            r_du_b      <= w_nxt_du_b;
            r_du_c      <= w_nxt_du_c;
            r_du_d      <= w_nxt_du_d;
            r_du_e      <= w_nxt_du_e;
            r_du_sel    <= w_nxt_du_sel;
            r_res_valid <= w_nxt_res_valid;
            r_res_word  <= w_nxt_res_word;
            r_res_sel   <= w_nxt_res_sel;
            r_res_last  <= w_nxt_res_last;
            r_err_pulse <= w_nxt_err_pulse;
            r_err_mask  <= w_nxt_err_mask;
            r_err_count <= w_nxt_err_count;
        end
    end

    // Next state and next register values; the check result is registered on
    // the final sweep edge so err_pulse and err_mask are visible in CHECK
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_in_ready  = r_in_ready;
        w_nxt_du_a      = r_du_a;
        w_nxt_du_b      = r_du_b;
        w_nxt_du_c      = r_du_c;
        w_nxt_du_d      = r_du_d;
        w_nxt_du_e      = r_du_e;
        w_nxt_du_sel    = r_du_sel;
        w_nxt_res_valid = r_res_valid;
        w_nxt_res_word  = r_res_word;
        w_nxt_res_sel   = r_res_sel;
        w_nxt_res_last  = r_res_last;
        w_nxt_err_pulse = 1'b0;
        w_nxt_err_mask  = r_err_mask;
        w_nxt_err_count = r_err_count;
        w_wr_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_nxt_du_a     = bus.in_a;
                    w_nxt_du_b     = bus.in_b;
                    w_nxt_du_c     = bus.in_c;
                    w_nxt_du_d     = bus.in_d;
                    w_nxt_du_e     = bus.in_e;
                    w_nxt_du_sel   = '0;
                    w_nxt_in_ready = 1'b0;
                    w_nxt_state    = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_wr_en      = 1'b1;
                w_nxt_du_sel = r_du_sel + 3'd1;
                if (r_du_sel == SEL_LAST) begin
                    w_nxt_state     = ST_CHECK;
                    w_nxt_err_mask  = w_mask;
                    w_nxt_err_pulse = |w_mask;
                    if ((|w_mask) && (r_err_count != {CNT_W{1'b1}})) begin
                        w_nxt_err_count = r_err_count + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                w_nxt_res_valid = 1'b1;
                w_nxt_res_word  = w_rd_data;
                w_nxt_res_sel   = SEL_T1;
                w_nxt_res_last  = 1'b0;
                w_nxt_state     = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.res_ready) begin
                    if (r_res_sel == SEL_LAST) begin
                        w_nxt_res_valid = 1'b0;
                        w_nxt_res_last  = 1'b0;
                        w_nxt_in_ready  = 1'b1;
                        w_nxt_state     = ST_IDLE;
                    end else begin
                        w_nxt_res_word  = w_rd_data;
                        w_nxt_res_sel   = w_rd_idx;
                        w_nxt_res_last  = (w_rd_idx == SEL_LAST);
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.du_a      = r_du_a;
    assign bus.du_b      = r_du_b;
    assign bus.du_c      = r_du_c;
    assign bus.du_d      = r_du_d;
    assign bus.du_e      = r_du_e;
    assign bus.du_sel    = r_du_sel;
    assign bus.res_valid = r_res_valid;
    assign bus.res_word  = r_res_word;
    assign bus.res_sel   = r_res_sel;
    assign bus.res_last  = r_res_last;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_mask  = r_err_mask;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_arith_sweep_monitor.sv
// Directed bench for arith_sweep_monitor with a behavioural datapath model.
// Define ARITH_MON_GOLDEN_EN to also exercise the golden compare.
module tb_arith_sweep_monitor;
    import arith_mon_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   fault_mode;

    arith_mon_if bus ();

    arith_sweep_monitor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model; fault_mode 1 corrupts sel1, mode 2 corrupts sel0 and sel1 alike
    always_comb begin
        logic [15:0] a, b, c, d, e;
        a = 16'(bus.du_a); b = 16'(bus.du_b); c = 16'(bus.du_c);
        d = 16'(bus.du_d); e = 16'(bus.du_e);
        case (bus.du_sel)
            3'd0:    bus.du_y = a * (b + c);
            3'd1:    bus.du_y = a * b + a * c;
            3'd2:    bus.du_y = (d + e) * (a + b);
            3'd3:    bus.du_y = d * a + d * b + e * a + e * b;
            3'd4:    bus.du_y = a * b;
            3'd5:    bus.du_y = a * c;
            3'd6:    bus.du_y = d * a;
            default: bus.du_y = e * b;
        endcase
        if (fault_mode == 1 && bus.du_sel == 3'd1) bus.du_y = bus.du_y + 16'd1;
        if (fault_mode == 2 && bus.du_sel <= 3'd1) bus.du_y = bus.du_y + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operand set: accept, sweep, check, emit with optional stall
    task automatic run_set(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] e,
                           input logic [7:0][15:0] exp_w, input int exp_mask,
                           input int exp_count, input int stall_idx);
        int pulses;
        logic [15:0] held_word;
        pulses = 0;
        for (int k = 0; k < 40 && !bus.in_ready; k++) tick();
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d; bus.in_e = e;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        check("du_a", 32'(bus.du_a), 32'(a));
        check("du_sel_start", 32'(bus.du_sel), 32'd0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (bus.err_pulse) pulses++;
            tick();
        end
        check("sweep_pulses", 32'(pulses), 32'd0);
        check("err_pulse_chk", 32'(bus.err_pulse), 32'(exp_mask != 0));
        check("err_mask", 32'(bus.err_mask), 32'(exp_mask));
        check("err_count", 32'(bus.err_count), 32'(exp_count));
        check("valid_in_chk", 32'(bus.res_valid), 32'd0);
        tick();
        check("err_pulse_after", 32'(bus.err_pulse), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_idx) begin
                bus.res_ready = 1'b0;
                held_word = bus.res_word;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_valid", 32'(bus.res_valid), 32'd1);
                    check("stall_word", 32'(bus.res_word), 32'(held_word));
                    check("stall_sel", 32'(bus.res_sel), 32'(i));
                end
                bus.res_ready = 1'b1;
            end
            check($sformatf("valid%0d", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("word%0d", i), 32'(bus.res_word), 32'(exp_w[i]));
            check($sformatf("sel%0d", i), 32'(bus.res_sel), 32'(i));
            check($sformatf("last%0d", i), 32'(bus.res_last), 32'(i == 7));
            tick();
        end
        check("valid_end", 32'(bus.res_valid), 32'd0);
        check("in_ready_end", 32'(bus.in_ready), 32'd1);
        check("err_mask_hold", 32'(bus.err_mask), 32'(exp_mask));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_du"}, {bus.du_a, bus.du_b, bus.du_c, bus.du_d}, 32'd0);
        check({tag, "_du_e_sel"}, {16'd0, bus.du_e, 5'd0, bus.du_sel}, 32'd0);
        check({tag, "_res"}, {12'd0, bus.res_valid, bus.res_last, bus.res_sel, bus.res_word}, 32'd0);
        check({tag, "_err"}, {bus.err_pulse, 3'(bus.err_mask), 12'd0, bus.err_count}, 32'd0);
    endtask

    logic [7:0][15:0] w_s1, w_s2;

    initial begin
        n_checks = 0; n_fail = 0; fault_mode = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.res_ready = 1'b1;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0; bus.in_e = '0;
        // words listed sel7 down to sel0
        w_s1 = {16'd4, 16'd6, 16'd15, 16'd12, 16'd21, 16'd21, 16'd27, 16'd27};
        w_s2 = {16'h0000, 16'h0000, 16'hFE01, 16'hFE01, 16'h0000, 16'h0000, 16'hFC02, 16'hFC02};
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        check_reset_vals("post_rst");

        run_set(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, w_s1, 0, 0, -1);
        run_set(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, w_s2, 0, 0, 3);

        fault_mode = 1;
        w_s1[1] = 16'd28;
        run_set(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, w_s1, 1, 1, -1);
        run_set(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, w_s1, 1, 2, -1);
        fault_mode = 0;
        w_s1[1] = 16'd27;

        // Reset in the middle of a sweep
        bus.in_a = 8'd9; bus.in_b = 8'd9; bus.in_c = 8'd9; bus.in_d = 8'd9; bus.in_e = 8'd9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run_set(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, w_s1, 0, 0, -1);

`ifdef ARITH_MON_GOLDEN_EN
        fault_mode = 2;
        w_s1[0] = 16'd28;
        w_s1[1] = 16'd28;
        run_set(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, w_s1, 4, 1, -1);
        fault_mode = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_sweep_monitor.md
# arith_sweep_monitor

Runtime integrity monitor that drives the 8-way combinational arithmetic datapath, the unit computing `a*(b+c)`, `(a*b)+(a*c)`, `(d+e)*(a+b)` and their expansions under a 3-bit select. For each accepted operand set it sweeps `sel` 0..7, captures all eight 16-bit results, and checks the two algebraic identities the datapath must satisfy modulo 2^16. It then streams the captured words out and flags mismatches. It sits on the operand/select side of the datapath, as that unit's initiator and consumer, and is used for trojan/fault detection.

## Interface
- NUM_SEL, 8, number of select codes swept; fixed by datapath select width.
- CNT_W, 16, width of saturating error counter.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  monitor can accept operands
- in_a, in_b, in_c, in_d, in_e  in  8 each  operands
- du_a, du_b, du_c, du_d, du_e  out  8 each  registered operands to datapath
- du_sel  out  3  registered select to datapath
- du_y  in  16  datapath result, combinational from du_* and du_sel
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts result word
- res_word  out  16  captured datapath result
- res_sel  out  3  select code that produced res_word
- res_last  out  1  marks word with res_sel==7
- err_pulse  out  1  one-cycle pulse on identity mismatch
- err_mask  out  2  bit0: y[sel0]!=y[sel1]; bit1: y[sel2]!=y[sel3]; held until next CHECK
- err_count  out  CNT_W  saturating count of operand sets with any mismatch

## Operation
- States: IDLE, SWEEP, CHECK, EMIT.
- IDLE: in_ready=1. On in_valid&in_ready, latch operands into du_a..du_e, set du_sel=0, go to SWEEP.
- SWEEP: every cycle capture du_y into buf[du_sel] and increment du_sel. After capturing du_sel==7, go to CHECK. du_sel then returns to 0.
- CHECK, one cycle:
  - Compare buf[0] with buf[1] and buf[2] with buf[3] at full 16 bits.
  - Load err_mask.
  - If err_mask!=0, assert err_pulse and increment err_count. err_count saturates at all-ones.
  - Go to EMIT with idx=0.
- EMIT:
  - res_valid=1, res_word=buf[idx], res_sel=idx, res_last=(idx==7).
  - On res_valid&res_ready, increment idx. After the handshake at idx==7, go to IDLE.
- Arithmetic: no truncation inside the monitor. Comparisons are exact 16-bit equality. Datapath results are already modulo 2^16.
- in_valid outside IDLE is ignored; in_ready=0 there.
- Reset values:
  - state=IDLE, in_ready=1.
  - du_*=0, du_sel=0.
  - res_valid=0, res_word=0, res_sel=0, res_last=0.
  - err_pulse=0, err_mask=0, err_count=0.
  - buf contents are don't-care.
- Reset mid-operation: abort immediately to reset values. The partial sweep is discarded and err_count is cleared.

## Timing
- Cycle 0: input handshake edge. Cycles 1..8: SWEEP captures sel 0..7. Cycle 9: CHECK. Cycle 10: first res_valid.
- With res_ready held high, res_last handshakes at cycle 17 and in_ready rises at cycle 18. Throughput is one operand set per 18 cycles.
- res_word, res_sel and res_last stay stable while res_valid&!res_ready.
- du_y must settle within one clock of du_sel/du_* changing.
- err_pulse is asserted for exactly the CHECK cycle.

## Configuration
- ARITH_MON_GOLDEN_EN defined:
  - CHECK also compares buf[0] against an internal 16-bit golden `a*(b+c)` computed from the latched operands.
  - err_mask widens to 3 bits; bit2 = golden mismatch.
- Not defined: no internal multiplier, and err_mask is 2 bits.

## Structure
- Shared package arith_mon_pkg holds:
  - state enum.
  - SEL_W=3, WORD_W=16, OPND_W=8.
  - Identity index constants: SEL_T1=0, SEL_T2=1, SEL_T3=2, SEL_T4=3, SEL_LAST=7.
- Sub-module arith_mon_buf: 8x16 capture buffer with write-by-sel and read-by-idx.
- FSM, comparator and counter stay in the top module.

## Test plan
- a=3,b=4,c=5,d=2,e=1 with a healthy datapath -> words sel0..3 = 27,27,21,21; err_mask=0; err_pulse never asserted; err_count=0.
- a=b=c=255, d=e=0 -> buf[0]=buf[1]=0xFC02 (overflow wraps); err_mask=0.
- Datapath model adds 1 to the sel=1 result, same operands as the first scenario -> err_mask=01, one err_pulse in cycle 9, err_count=1. Repeating the set gives err_count=2.
- res_ready low for 5 cycles at idx=3 -> res_word/res_sel frozen at word 3 and sel 3. All 8 words are delivered once, in order, and res_last is on sel 7 only.
- Assert rst_n=0 at cycle 5 of a sweep -> all outputs at reset values. A new set accepted after release completes normally.
- With ARITH_MON_GOLDEN_EN: datapath model corrupts both sel0 and sel1 identically -> err_mask=100, err_count=1.
